// File: rtl/weight_ram_loader_pkg.sv
// Shared weight-memory widths and loader FSM encoding, common to the
// weight RAM loader and the fixed weight ROM users.
package weight_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    ACK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/weight_ram_loader_ram_sdp.sv
// Simple dual-port weight array: one clocked write port, one read port.
// The read register sits in the parent so the array itself needs no reset.
module ram_sdp #(
  parameter int ADDR_WIDTH = weight_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = weight_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  import weight_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Sampled by the parent's read register, so a same-cycle write yields old data.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_ram_loader.sv
// Loads NUM_WORDS bytes from the UART receiver into the weight RAM and
// serves them to the datapath through a 1-cycle registered read port.
module weight_ram_loader #(
  parameter int ADDR_WIDTH = weight_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = weight_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_rdy_i,
  output logic                  clr_rx_rdy_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            chksum_o
);

  import weight_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  loader_state_t         state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  clr_q;
  logic [7:0]            chksum_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  wr_en_d;

  assign wr_en_d = (state_q == WAIT_BYTE) && rx_rdy_i;

  ram_sdp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (wr_en_d),
    .waddr_i(wr_addr_q),
    .wdata_i(rx_data_i),
    .raddr_i(rd_addr_i),
    .rdata_o(rd_data_d)
  );

  // start is only honoured in IDLE/DONE, so an in-flight load always completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
      chksum_q  <= 8'h00;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= WAIT_BYTE;
            wr_addr_q <= '0;
            chksum_q  <= 8'h00;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        WAIT_BYTE: begin
          if (rx_rdy_i) begin
            chksum_q <= chksum_q + rx_data_i[7:0];
            clr_q    <= 1'b1;
            state_q  <= ACK;
          end
        end
        ACK: begin
          if (wr_addr_q == LAST_ADDR) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
            state_q   <= WAIT_BYTE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= rd_data_d;
    end
  end

  assign q_o          = q_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign clr_rx_rdy_o = clr_q;
  assign chksum_o     = chksum_q;

endmodule
